// File: rtl/msrv_32_integer_file_if.sv
// Writeback and read-port bundle for the integer register file.
// The master drives writeback and read addresses; the slave returns data and commit status.
interface msrv_32_integer_file_if #(
    parameter int XLEN    = 32,
    parameter int NREG_AW = 5
);
    logic               wr_en_in;
    logic               stall_in;
    logic               flush_in;
    logic [NREG_AW-1:0] rd_in;
    logic [XLEN-1:0]    rd_data_in;
    logic [NREG_AW-1:0] rs1_addr_in;
    logic [NREG_AW-1:0] rs2_addr_in;
    logic [XLEN-1:0]    rs1_out;
    logic [XLEN-1:0]    rs2_out;
    logic               wr_commit_out;
    logic [NREG_AW-1:0] wr_rd_out;

    modport master (
        output wr_en_in, stall_in, flush_in,
        output rd_in, rd_data_in,
        output rs1_addr_in, rs2_addr_in,
        input  rs1_out, rs2_out,
        input  wr_commit_out, wr_rd_out
    );

    modport slave (
        input  wr_en_in, stall_in, flush_in,
        input  rd_in, rd_data_in,
        input  rs1_addr_in, rs2_addr_in,
        output rs1_out, rs2_out,
        output wr_commit_out, wr_rd_out
    );
endinterface

// File: rtl/msrv_32_integer_file.sv
// Integer register file x0..x31 with two combinational read ports,
// optional same-cycle write forwarding and a registered commit report.
module msrv_32_integer_file #(
    parameter int          XLEN      = 32,
    parameter int          NREG_AW   = 5,
    parameter logic [31:0] RESET_VAL = 32'h0,
    parameter int          BYPASS_EN = 1
) (
    input logic                    ms_riscv32_mp_clk_in,
    input logic                    ms_riscv32_mp_rst_in,
    msrv_32_integer_file_if.slave  rf
);
    localparam int NREG = 1 << NREG_AW;

    logic [XLEN-1:0]    regs [1:NREG-1];
    logic               commit;
    logic               bypass;
    logic               commit_q;
    logic [NREG_AW-1:0] rd_q;

    assign commit = rf.wr_en_in & ~rf.stall_in & ~rf.flush_in
                  & (rf.rd_in != '0) & ~ms_riscv32_mp_rst_in;
    assign bypass = (BYPASS_EN != 0) && commit;

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            for (int i = 1; i < NREG; i++) begin
                regs[i] <= RESET_VAL[XLEN-1:0];
            end
            commit_q <= 1'b0;
            rd_q     <= '0;
        end else begin
            commit_q <= commit;
            if (commit) begin
                regs[rf.rd_in] <= rf.rd_data_in;
                rd_q           <= rf.rd_in;
            end
        end
    end

    // x0 wins over forwarding, so a write aimed at x0 never leaks out.
    always_comb begin
        rf.rs1_out = '0;
        if (rf.rs1_addr_in != '0) begin
            if (bypass && (rf.rd_in == rf.rs1_addr_in)) begin
                rf.rs1_out = rf.rd_data_in;
            end else begin
                rf.rs1_out = regs[rf.rs1_addr_in];
            end
        end
    end

    always_comb begin
        rf.rs2_out = '0;
        if (rf.rs2_addr_in != '0) begin
            if (bypass && (rf.rd_in == rf.rs2_addr_in)) begin
                rf.rs2_out = rf.rd_data_in;
            end else begin
                rf.rs2_out = regs[rf.rs2_addr_in];
            end
        end
    end

    assign rf.wr_commit_out = commit_q;
    assign rf.wr_rd_out     = rd_q;
endmodule

// File: tb/tb_msrv_32_integer_file.sv
// Randomised and directed bench: forwarding and non-forwarding instances
// checked against an array model of the architectural registers.
module tb_msrv_32_integer_file;
    localparam logic [31:0] RV = 32'hCAFE_0001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    msrv_32_integer_file_if #(.XLEN(32), .NREG_AW(5)) aif ();
    msrv_32_integer_file_if #(.XLEN(32), .NREG_AW(5)) bif ();

    assign bif.wr_en_in    = aif.wr_en_in;
    assign bif.stall_in    = aif.stall_in;
    assign bif.flush_in    = aif.flush_in;
    assign bif.rd_in       = aif.rd_in;
    assign bif.rd_data_in  = aif.rd_data_in;
    assign bif.rs1_addr_in = aif.rs1_addr_in;
    assign bif.rs2_addr_in = aif.rs2_addr_in;

    msrv_32_integer_file #(
        .XLEN(32), .NREG_AW(5), .RESET_VAL(RV), .BYPASS_EN(1)
    ) dut_byp (
        .ms_riscv32_mp_clk_in(clk),
        .ms_riscv32_mp_rst_in(rst),
        .rf(aif)
    );

    msrv_32_integer_file #(
        .XLEN(32), .NREG_AW(5), .RESET_VAL(RV), .BYPASS_EN(0)
    ) dut_nob (
        .ms_riscv32_mp_clk_in(clk),
        .ms_riscv32_mp_rst_in(rst),
        .rf(bif)
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_on = 1'b0;

    logic [31:0] mem [32];
    logic        m_commit;
    logic [4:0]  m_rd;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp,
                                           input bit cm, input logic [4:0] rd,
                                           input logic [31:0] d);
        if (a == 0) return 32'h0;
        if (byp && cm && rd == a) return d;
        return mem[a];
    endfunction

    task automatic cyc(input bit we, input bit st, input bit fl, input bit rs,
                       input logic [4:0] rd, input logic [31:0] d,
                       input logic [4:0] a1, input logic [4:0] a2);
        bit cm;
        aif.wr_en_in    = we;
        aif.stall_in    = st;
        aif.flush_in    = fl;
        rst             = rs;
        aif.rd_in       = rd;
        aif.rd_data_in  = d;
        aif.rs1_addr_in = a1;
        aif.rs2_addr_in = a2;
        cm = we && !st && !fl && rd != 0 && !rs;
        #1;
        if (chk_on) begin
            chk("byp_rs1", aif.rs1_out, exp_rd(a1, 1'b1, cm, rd, d));
            chk("byp_rs2", aif.rs2_out, exp_rd(a2, 1'b1, cm, rd, d));
            chk("nob_rs1", bif.rs1_out, exp_rd(a1, 1'b0, cm, rd, d));
            chk("nob_rs2", bif.rs2_out, exp_rd(a2, 1'b0, cm, rd, d));
        end
        @(posedge clk);
        if (rs) begin
            for (int i = 1; i < 32; i++) mem[i] = RV;
            m_commit = 1'b0;
            m_rd     = 5'd0;
        end else begin
            m_commit = cm;
            if (cm) begin
                mem[rd] = d;
                m_rd    = rd;
            end
        end
        #1;
        if (rs) chk_on = 1'b1;
        if (chk_on) begin
            chk("byp_commit", {31'b0, aif.wr_commit_out}, {31'b0, m_commit});
            chk("nob_commit", {31'b0, bif.wr_commit_out}, {31'b0, m_commit});
            chk("byp_wr_rd", {27'b0, aif.wr_rd_out}, {27'b0, m_rd});
            chk("nob_wr_rd", {27'b0, bif.wr_rd_out}, {27'b0, m_rd});
        end
    endtask

    task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, a1, a2);
    endtask

    initial begin
        mem[0] = 32'h0;
        m_commit = 1'b0;
        m_rd = 5'd0;
        @(negedge clk);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0, 5'd0, 5'd0);

        for (int i = 1; i < 32; i++) idle(5'(i), 5'(32 - i));

        cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
        idle(5'd0, 5'd5);

        cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        idle(5'd0, 5'd0);

        cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 32'h11, 5'd1, 5'd2);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 32'h22, 5'd7, 5'd7);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 5'd7, 32'h22, 5'd7, 5'd7);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 5'd7, 32'h22, 5'd7, 5'd7);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 32'h22, 5'd3, 5'd7);
        idle(5'd7, 5'd7);

        cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 32'd1, 5'd9, 5'd9);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 32'd2, 5'd9, 5'd9);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 32'd3, 5'd9, 5'd9);
        idle(5'd9, 5'd9);

        cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 32'h1234, 5'd3, 5'd4);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd3);
        idle(5'd3, 5'd3);

        for (int n = 0; n < 600; n++) begin
            logic [4:0] rd, a1, a2;
            bit we, st, fl, rs;
            rd = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) rd = 5'd0;
            a1 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
            we = $urandom_range(0, 3) != 0;
            st = $urandom_range(0, 7) == 0;
            fl = $urandom_range(0, 7) == 0;
            rs = $urandom_range(0, 49) == 0;
            cyc(we, st, fl, rs, rd, $urandom, a1, a2);
        end

        for (int i = 1; i < 32; i++) idle(5'(i), 5'(i));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
